// File: rtl/vga_timing.sv
// vga_timing: pixel-clock divider plus horizontal/vertical raster counters.
// Sync, blanking and frame flags are registered alongside the counters.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] col,
  output logic [31:0] row,
  output logic        hsync,
  output logic        vsync,
  output logic        vnotactive,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int RW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] V_LAST = RW'(V_TOTAL - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIX_DIV - 1);

  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] H_VIS  = 32'(H_ACTIVE);
  localparam logic [31:0] V_VIS  = 32'(V_ACTIVE);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_n;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_n;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_n;
  logic          tick;
  logic          col_wrap;
  logic          row_wrap;
  logic          frame_wrap;
  logic [31:0]   col_x;
  logic [31:0]   row_x;
  logic          hs_n;
  logic          vs_n;
  logic          vn_n;
  logic          hs_q;
  logic          vs_q;
  logic          vn_q;
  logic          fs_q;
  logic [15:0]   fc_q;

  // Next raster position, evaluated for use on a tick edge.
  always_comb begin
    tick       = (div_q == D_LAST);
    div_n      = tick ? '0 : div_q + DW'(1);
    col_wrap   = (col_q == H_LAST);
    row_wrap   = (row_q == V_LAST);
    col_n      = col_wrap ? '0 : col_q + CW'(1);
    row_n      = row_q;
    if (col_wrap) begin
      row_n = row_wrap ? '0 : row_q + RW'(1);
    end
    frame_wrap = tick && col_wrap && row_wrap;
  end

  // Flags decoded from the next position so they land with the counters.
  always_comb begin
    col_x = 32'(col_n);
    row_x = 32'(row_n);
    hs_n  = !((col_x >= HS_BEG) && (col_x < HS_END));
    vs_n  = !((row_x >= VS_BEG) && (row_x < VS_END));
    vn_n  = (col_x >= H_VIS) || (row_x >= V_VIS);
  end

  // Divider, counters, flags and frame bookkeeping; reset wins over tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
      col_q <= '0;
      row_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vn_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      div_q <= div_n;
      fs_q  <= frame_wrap;
      if (tick) begin
        col_q <= col_n;
        row_q <= row_n;
        hs_q  <= hs_n;
        vs_q  <= vs_n;
        vn_q  <= vn_n;
      end
      if (frame_wrap) begin
        fc_q <= fc_q + 16'd1;
      end
    end
  end

  assign col         = 32'(col_q);
  assign row         = 32'(row_q);
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vnotactive  = vn_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing.
// Three instances: defaults, a 7x5 raster at PIX_DIV 3, and a 1x1 raster.
module tb_vga_timing;

  typedef struct packed {
    logic [31:0] col;
    logic [31:0] row;
    logic        hs;
    logic        vs;
    logic        vn;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int    inst;
    int    n;
    string tag;
    obs_t  v;
  } ent_t;

  logic CLK  = 1'b0;
  logic RST  = 1'b1;
  logic RST1 = 1'b1;

  logic [31:0] col0, row0, col1, row1, col2, row2;
  logic        hs0, vs0, vn0, fs0;
  logic        hs1, vs1, vn1, fs1;
  logic        hs2, vs2, vn2, fs2;
  logic [15:0] fc0, fc1, fc2;

  int   n0 = 0;
  int   n1 = 0;
  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  always #5 CLK = ~CLK;

  // Edges since the last reset edge, per reset domain.
  always @(posedge CLK) n0 <= RST ? 0 : n0 + 1;
  always @(posedge CLK) n1 <= RST1 ? 0 : n1 + 1;

  vga_timing u_def (
    .CLK(CLK), .RST(RST),
    .col(col0), .row(row0),
    .hsync(hs0), .vsync(vs0),
    .vnotactive(vn0),
    .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(3)
  ) u_sml (
    .CLK(CLK), .RST(RST),
    .col(col1), .row(row1),
    .hsync(hs1), .vsync(vs1),
    .vnotactive(vn1),
    .frame_start(fs1), .frame_cnt(fc1)
  );

  vga_timing #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
    .PIX_DIV(1)
  ) u_one (
    .CLK(CLK), .RST(RST1),
    .col(col2), .row(row2),
    .hsync(hs2), .vsync(vs2),
    .vnotactive(vn2),
    .frame_start(fs2), .frame_cnt(fc2)
  );

  // Closed-form reference: state after n edges since reset release.
  function automatic obs_t model(int i, int n);
    int ha, hf, hw, hb, va, vf, vw, vb, pd;
    int ht, vt, t, c, r, f;
    obs_t o;
    case (i)
      0: begin
        ha = 640; hf = 16; hw = 96; hb = 48;
        va = 480; vf = 10; vw = 2;  vb = 33; pd = 2;
      end
      1: begin
        ha = 4; hf = 1; hw = 1; hb = 1;
        va = 2; vf = 1; vw = 1; vb = 1; pd = 3;
      end
      default: begin
        ha = 1; hf = 0; hw = 0; hb = 0;
        va = 1; vf = 0; vw = 0; vb = 0; pd = 1;
      end
    endcase
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    t  = n / pd;
    c  = t % ht;
    r  = (t / ht) % vt;
    f  = t / (ht * vt);
    o.col = 32'(c);
    o.row = 32'(r);
    o.hs  = !((c >= ha + hf) && (c < ha + hf + hw));
    o.vs  = !((r >= va + vf) && (r < va + vf + vw));
    o.vn  = (c >= ha) || (r >= va);
    o.fs  = (n > 0) && (n % pd == 0) && (t % (ht * vt) == 0);
    o.fc  = 16'(f);
    return o;
  endfunction

  function automatic obs_t obs(int i);
    obs_t o;
    case (i)
      0:       o = '{col0, row0, hs0, vs0, vn0, fs0, fc0};
      1:       o = '{col1, row1, hs1, vs1, vn1, fs1, fc1};
      default: o = '{col2, row2, hs2, vs2, vn2, fs2, fc2};
    endcase
    return o;
  endfunction

  function automatic int cnt(int i);
    return (i == 2) ? n1 : n0;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("col=%0d row=%0d hs=%b vs=%b vn=%b fs=%b fc=%0d",
                     o.col, o.row, o.hs, o.vs, o.vn, o.fs, o.fc);
  endfunction

  task automatic push(int i, int n, string tag);
    ent_t e;
    e.inst = i;
    e.n    = n;
    e.tag  = tag;
    e.v    = model(i, n);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    ent_t e;
    obs_t a;
    int   k;
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push(0, 0, "rst_hold_def");
      push(1, 0, "rst_hold_sml");
      k = 0;
      while (sb.size() > 0 && k < 4) begin
        @(posedge CLK); #1; k++;
        while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
          e = sb.pop_front(); a = obs(e.inst); checks++;
          if (a !== e.v) begin
            errors++;
            $display("FAIL %s n=%0d got %s want %s",
                     e.tag, e.n, fmt(a), fmt(e.v));
          end
        end
      end
      if (sb.size() > 0) begin
        checks++; errors++;
        $display("FAIL rst_hold timeout pending=%0d", sb.size());
        sb.delete();
      end
    end
    RST = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      push(0, n, "release_def");
      push(1, n, "release_sml");
    end
    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge CLK); #1; k++;
      while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
        e = sb.pop_front(); a = obs(e.inst); checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s n=%0d got %s want %s",
                   e.tag, e.n, fmt(a), fmt(e.v));
        end
      end
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL release timeout pending=%0d", sb.size());
      sb.delete();
    end
    checks++;
    if (col0 !== 32'd2 || row0 !== 32'd0 || vn0 !== 1'b0) begin
      errors++;
      $display("FAIL edge4_col got col=%0d row=%0d vn=%b want 2 0 0",
               col0, row0, vn0);
    end
  endtask

  task automatic test_hsync();
    ent_t e;
    obs_t a;
    int   k;
    for (int n = 5; n <= 1700; n++) push(0, n, "hline");
    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(posedge CLK); #1; k++;
      while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
        e = sb.pop_front(); a = obs(e.inst); checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s n=%0d got %s want %s",
                   e.tag, e.n, fmt(a), fmt(e.v));
        end
      end
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL hline timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_frames();
    ent_t e;
    obs_t a;
    int   k;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int n = 1; n <= 330; n++) push(1, n, "frames_sml");
    k = 0;
    while (sb.size() > 0 && k < 400) begin
      @(posedge CLK); #1; k++;
      while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
        e = sb.pop_front(); a = obs(e.inst); checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s n=%0d got %s want %s",
                   e.tag, e.n, fmt(a), fmt(e.v));
        end
      end
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL frames timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    obs_t a;
    int   k;
    push(1, 331, "pre_mid_sml");
    push(1, 332, "pre_mid_sml");
    push(-1, -1, "");
    void'(sb.pop_back());
    for (int step = 0; step < 4; step++) begin
      if (step == 1) begin
        RST = 1'b1;
        push(0, 0, "mid_rst_def");
        push(1, 0, "mid_rst_sml");
      end
      if (step == 2) begin
        RST = 1'b0;
        for (int n = 1; n <= 104; n++) push(1, n, "post_mid_sml");
      end
      if (step == 3) begin
        RST = 1'b1;
        push(0, 0, "wrap_rst_def");
        push(1, 0, "wrap_rst_sml");
      end
      k = 0;
      while (sb.size() > 0 && k < 200) begin
        @(posedge CLK); #1; k++;
        while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
          e = sb.pop_front(); a = obs(e.inst); checks++;
          if (a !== e.v) begin
            errors++;
            $display("FAIL %s n=%0d got %s want %s",
                     e.tag, e.n, fmt(a), fmt(e.v));
          end
        end
      end
      if (sb.size() > 0) begin
        checks++; errors++;
        $display("FAIL b2b timeout step=%0d pending=%0d", step, sb.size());
        sb.delete();
      end
    end
    RST = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      push(0, n, "resume_def");
      push(1, n, "resume_sml");
    end
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge CLK); #1; k++;
      while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
        e = sb.pop_front(); a = obs(e.inst); checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s n=%0d got %s want %s",
                   e.tag, e.n, fmt(a), fmt(e.v));
        end
      end
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL resume timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_wrap();
    ent_t e;
    obs_t a;
    int   k;
    for (int n = 65533; n <= 65538; n++) push(2, n, "fc_wrap");
    k = 0;
    while (sb.size() > 0 && k < 70000) begin
      @(posedge CLK); #1; k++;
      while (sb.size() > 0 && sb[0].n <= cnt(sb[0].inst)) begin
        e = sb.pop_front(); a = obs(e.inst); checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s n=%0d got %s want %s",
                   e.tag, e.n, fmt(a), fmt(e.v));
        end
      end
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL fc_wrap timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    RST  = 1'b1;
    RST1 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST1 = 1'b0;
    test_reset();
    test_hsync();
    test_frames();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter PIX_DIV, default 2, CLK cycles per pixel (>=1).
REQ-010 Port CLK, input, 1 bit; the single clock, rising edge only.
REQ-011 Port RST, input, 1 bit; synchronous, active-high reset.
REQ-012 Port col, output, 32 bits; current pixel column, zero-extended horizontal count.
REQ-013 Port row, output, 32 bits; current line, zero-extended vertical count.
REQ-014 Port hsync, output, 1 bit; active-low horizontal sync.
REQ-015 Port vsync, output, 1 bit; active-low vertical sync.
REQ-016 Port vnotactive, output, 1 bit; high when the current pixel is outside the visible area.
REQ-017 Port frame_start, output, 1 bit; one-CLK pulse on each wrap to (row 0, col 0).
REQ-018 Port frame_cnt, output, 16 bits; completed-frame count, wraps modulo 65536.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-020 Divider counts 0..PIX_DIV-1 every CLK; pixel tick is asserted in the cycle where divider == PIX_DIV-1; with PIX_DIV=1, tick is asserted every cycle.
REQ-021 On a tick edge: col increments; col == H_TOTAL-1 wraps to 0 and advances row.
REQ-022 row == V_TOTAL-1 together with col wrap causes row to wrap to 0.
REQ-023 col, row, hsync, vsync and vnotactive are registered, change only on tick edges, and always describe the same pixel (zero skew between them).
REQ-024 hsync = 0 iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (default 656..751); otherwise 1.
REQ-025 vsync = 0 iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (default 490..491); otherwise 1.
REQ-026 vnotactive = 1 iff col >= H_ACTIVE or row >= V_ACTIVE.
REQ-027 On the tick edge that moves (row, col) from (V_TOTAL-1, H_TOTAL-1) to (0, 0): frame_start = 1 for exactly that one following CLK cycle, and frame_cnt increments by 1 in that edge.
REQ-028 frame_start = 0 in all other cycles, including non-tick cycles where the counters hold (0, 0).
REQ-029 frame_cnt at 16'hFFFF wraps to 0 on the next frame wrap with no other side effect.

Reset
REQ-030 RST high at a CLK edge: divider = 0, col = 0, row = 0, hsync = 1, vsync = 1, vnotactive = 0, frame_start = 0, frame_cnt = 0.
REQ-031 Reset has priority over a coincident tick; reset asserted mid-line or mid-frame produces the REQ-030 state on the next edge with no frame_start pulse.
REQ-032 Reset held for N cycles holds the REQ-030 state; counting resumes from the first edge with RST low, and the first tick occurs PIX_DIV edges after release.

Verification
REQ-033 Defaults; RST for 1 cycle, then release -> col = 0 after edge 1, col = 1 after edge 2, then col = 2 after edge 4; row = 0; vnotactive = 0.
REQ-034 Defaults; run 1280 CLK after reset -> col = 640, vnotactive = 1, hsync = 1; at col = 656, hsync = 0; it stays low for 96 pixels (192 CLK); at col = 752, hsync = 1.
REQ-035 Defaults; run to row = 490 -> vsync = 0 for 2 lines (3200 CLK); row = 492 -> vsync = 1; vnotactive = 1 for all of rows 480..524.
REQ-036 Defaults; run 840000 CLK from reset release -> row = 0, col = 0, frame_start = 1 for one cycle, frame_cnt = 1; second frame -> frame_cnt = 2.
REQ-037 Defaults; RST pulsed when row = 100, col = 300 -> next edge col = 0, row = 0, hsync = 1, vsync = 1, frame_cnt = 0, frame_start = 0.
REQ-038 Small config (H 4/1/1/1, V 2/1/1/1, PIX_DIV 1); run 65536 frames -> frame_cnt wraps from 16'hFFFF to 0 with frame_start = 1, and the sync pulse positions are unchanged.
